effect_sequencer: RTL and testbench
===================================

EFFECT_SEQUENCER -- requirements
Module: effect_sequencer

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, number of cycles a sound/motion effect stays asserted (legal range 1..15).
REQ-002 Parameter: FIFO_DEPTH, default 4, number of opcode entries buffered (power of two).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 op_valid  input  1  upstream fetch stage presents an opcode.
REQ-006 opcode  input  4  opcode; [3:2]=class (00 system, 01 color, 10 sound, 11 motion), [1:0]=item.
REQ-007 op_ready  output  1  block accepts the opcode this cycle.
REQ-008 enabled  output  1  decoration powered on.
REQ-009 led_color  output  2  00 off, 01 green, 10 purple, 11 orange.
REQ-010 sound  output  2  00 silent, 01 scream, 10 cackle, 11 boo.
REQ-011 motion  output  2  00 idle, 01 wave hands, 10 move jaw, 11 fog.
REQ-012 busy  output  1  high when state != IDLE or FIFO non-empty.
REQ-013 err_cnt  output  4  count of undefined opcodes, saturating.

Function
REQ-014 Transfer occurs on a rising edge where op_valid && op_ready; the opcode is written to the FIFO tail.
REQ-015 op_ready = !fifo_full && !(state==EXEC && cur_op==RESET); no push when full even if a pop occurs the same edge.
REQ-016 Opcode map: 0000 ON, 0001 RESET, 0100 GREEN, 0101 PURPLE, 0110 ORANGE, 1000 SCREAM, 1001 CACKLE, 1010 BOO, 1100 WAVE, 1101 JAW, 1110 FOG; 0010, 0011, 0111, 1011, 1111 are undefined.
REQ-017 FSM states: IDLE, EXEC, HOLD.
REQ-018 IDLE: if FIFO non-empty, pop head into cur_op, go EXEC; else stay.
REQ-019 EXEC (one cycle): apply cur_op per REQ-020..025 at exit edge; go HOLD if a sound/motion effect was started, else IDLE.
REQ-020 ON: enabled<=1; no other output change.
REQ-021 RESET: enabled<=0, led_color<=00, sound<=00, motion<=00, FIFO flushed to empty.
REQ-022 Color opcode with enabled=1: led_color<=item+1 (GREEN 01, PURPLE 10, ORANGE 11); persists until the next color opcode, RESET, or rst.
REQ-023 Sound opcode with enabled=1: sound<=code per REQ-010, motion unchanged (00), hold counter<=HOLD_CYCLES-1.
REQ-024 Motion opcode with enabled=1: motion<=code per REQ-011, hold counter<=HOLD_CYCLES-1.
REQ-025 Color/sound/motion opcode with enabled=0: discarded, no output change, err_cnt unchanged; undefined opcode: discarded, err_cnt increments, saturating at 15, regardless of enabled.
REQ-026 HOLD: if counter==0, clear sound and motion to 00 and go IDLE; else decrement counter.
REQ-027 Sound/motion is therefore asserted for exactly HOLD_CYCLES cycles; at most one of sound/motion is non-zero at any time.
REQ-028 Latency: an opcode accepted at edge N into an empty FIFO with state IDLE is popped at edge N+1; its outputs update at edge N+2.
REQ-029 Pushes continue during EXEC/HOLD while FIFO not full; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 On rst assertion, immediately and independent of clk: state IDLE, FIFO empty, enabled=0, led_color=00, sound=00, motion=00, err_cnt=0, busy=0, op_ready=1 one cycle after rst deasserts and remains 1 while rst is low and FIFO not full.
REQ-031 rst asserted mid-HOLD aborts the effect; queued entries are lost.

Verification
REQ-032 rst, push ON then GREEN -> enabled=1, led_color=01 from 2 cycles after GREEN accepted, held indefinitely.
REQ-033 After ON, push BOO (HOLD_CYCLES=4) at edge N -> sound=11 from edge N+2 to N+6, then 00; busy low at N+6.
REQ-034 From rst, push SCREAM without ON -> sound stays 00, err_cnt=0, busy returns low after 2 cycles.
REQ-035 After ON, 6 back-to-back pushes (WAVE then 5xJAW) with op_valid held -> op_ready low once FIFO holds 4; remaining push accepted when head popped; all effects execute in order, each 4 cycles.
REQ-036 Push 0011 seventeen times -> err_cnt counts 1..15, stays 15.
REQ-037 ON, ORANGE, RESET, FOG queued -> RESET flushes FOG: led_color=00, enabled=0, motion never 11; separate run: rst pulsed mid-HOLD -> all outputs 0 immediately.

Source files
------------

// File: rtl/effect_sequencer.sv
// Opcode sequencer for a decoration controller: buffers 4-bit opcodes in a small FIFO
// and plays them through an IDLE/EXEC/HOLD machine driving power, LED, sound and motion.
module effect_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [3:0] opcode,
    output logic       op_ready,
    output logic       enabled,
    output logic [1:0] led_color,
    output logic [1:0] sound,
    output logic [1:0] motion,
    output logic       busy,
    output logic [3:0] err_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_CNT = PW'(FIFO_DEPTH);
    localparam logic [3:0]  HOLD_INIT = 4'(HOLD_CYCLES - 1);

    localparam logic [3:0] OP_ON     = 4'b0000;
    localparam logic [3:0] OP_RESET  = 4'b0001;
    localparam logic [3:0] OP_GREEN  = 4'b0100;
    localparam logic [3:0] OP_PURPLE = 4'b0101;
    localparam logic [3:0] OP_ORANGE = 4'b0110;
    localparam logic [3:0] OP_SCREAM = 4'b1000;
    localparam logic [3:0] OP_CACKLE = 4'b1001;
    localparam logic [3:0] OP_BOO    = 4'b1010;
    localparam logic [3:0] OP_WAVE   = 4'b1100;
    localparam logic [3:0] OP_JAW    = 4'b1101;
    localparam logic [3:0] OP_FOG    = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cur_op_q, cur_op_d;
    logic [3:0]  hold_q, hold_d;
    logic        enabled_q, enabled_d;
    logic [1:0]  led_q, led_d;
    logic [1:0]  sound_q, sound_d;
    logic [1:0]  motion_q, motion_d;
    logic [3:0]  err_q, err_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]  fifo_q [2**AW];

    logic [AW:0] fifo_count;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == DEPTH_CNT);
    // Pushes are blocked while a RESET executes so the flush cannot race a new entry.
    assign op_ready   = !fifo_full && !(state_q == S_EXEC && cur_op_q == OP_RESET);
    assign push       = op_valid && op_ready;

    always_comb begin
        state_d   = state_q;
        cur_op_d  = cur_op_q;
        hold_d    = hold_q;
        enabled_d = enabled_q;
        led_d     = led_q;
        sound_d   = sound_q;
        motion_d  = motion_q;
        err_d     = err_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    cur_op_d = fifo_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                case (cur_op_q)
                    OP_ON: begin
                        enabled_d = 1'b1;
                    end
                    OP_RESET: begin
                        enabled_d = 1'b0;
                        led_d     = 2'b00;
                        sound_d   = 2'b00;
                        motion_d  = 2'b00;
                        rd_ptr_d  = wr_ptr_q;
                    end
                    OP_GREEN, OP_PURPLE, OP_ORANGE: begin
                        if (enabled_q) begin
                            led_d = cur_op_q[1:0] + 2'd1;
                        end
                    end
                    OP_SCREAM, OP_CACKLE, OP_BOO: begin
                        if (enabled_q) begin
                            sound_d = cur_op_q[1:0] + 2'd1;
                            hold_d  = HOLD_INIT;
                            state_d = S_HOLD;
                        end
                    end
                    OP_WAVE, OP_JAW, OP_FOG: begin
                        if (enabled_q) begin
                            motion_d = cur_op_q[1:0] + 2'd1;
                            hold_d   = HOLD_INIT;
                            state_d  = S_HOLD;
                        end
                    end
                    default: begin
                        if (err_q != 4'hF) begin
                            err_d = err_q + 4'd1;
                        end
                    end
                endcase
            end
            S_HOLD: begin
                if (hold_q == 4'd0) begin
                    sound_d  = 2'b00;
                    motion_d = 2'b00;
                    state_d  = S_IDLE;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hold_q    <= 4'd0;
            enabled_q <= 1'b0;
            led_q     <= 2'b00;
            sound_q   <= 2'b00;
            motion_q  <= 2'b00;
            err_q     <= 4'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            enabled_q <= enabled_d;
            led_q     <= led_d;
            sound_q   <= sound_d;
            motion_q  <= motion_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Opcode storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        cur_op_q <= cur_op_d;
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= opcode;
        end
    end

    assign enabled   = enabled_q;
    assign led_color = led_q;
    assign sound     = sound_q;
    assign motion    = motion_q;
    assign err_cnt   = err_q;
    assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_effect_sequencer.sv
// Directed bench for effect_sequencer: reset, latency, hold timing, back-pressure,
// error saturation, RESET flush and asynchronous reset abort.
module tb_effect_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [3:0] opcode;
    logic       op_ready;
    logic       enabled;
    logic [1:0] led_color;
    logic [1:0] sound;
    logic [1:0] motion;
    logic       busy;
    logic [3:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    effect_sequencer #(
        .HOLD_CYCLES(4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .opcode   (opcode),
        .op_ready (op_ready),
        .enabled  (enabled),
        .led_color(led_color),
        .sound    (sound),
        .motion   (motion),
        .busy     (busy),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op);
        int waited;
        waited   = 0;
        op_valid = 1'b1;
        opcode   = op;
        while (!op_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!op_ready) check_val("push_ready", op_ready, 1'b1);
        tick();
        op_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check_val(tag, busy, 1'b0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        op_valid = 1'b0;
        opcode   = 4'h0;
        #2;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_snd;
        logic [1:0] exp_mot;
        logic       fire;
        int         n_acc;
        int         bad;
        int         saw_orange;
        int         saw_block;
        int         n;

        rst      = 1'b1;
        op_valid = 1'b0;
        opcode   = 4'h0;
        #2;
        check_val("rst_enabled", enabled, 1'b0);
        check_val("rst_led", led_color, 2'b00);
        check_val("rst_sound", sound, 2'b00);
        check_val("rst_motion", motion, 2'b00);
        check_val("rst_err", err_cnt, 4'd0);
        check_val("rst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check_val("rst_ready", op_ready, 1'b1);

        // ON then GREEN: colour latches and stays
        push(4'b0000);
        push(4'b0100);
        wait_idle("green_idle");
        check_val("on_enabled", enabled, 1'b1);
        check_val("green_led", led_color, 2'b01);
        repeat (5) tick();
        check_val("green_held", led_color, 2'b01);

        // BOO accepted at edge N: sound=11 from N+2 to N+6
        push(4'b1010);
        for (int k = 0; k <= 6; k++) begin
            exp_snd = (k >= 2 && k <= 5) ? 2'b11 : 2'b00;
            check_val($sformatf("boo_sound_k%0d", k), sound, exp_snd);
            if (k == 5) check_val("boo_busy_k5", busy, 1'b1);
            if (k == 6) check_val("boo_busy_k6", busy, 1'b0);
            if (k < 6) tick();
        end
        check_val("boo_led_kept", led_color, 2'b01);

        // SCREAM without ON is dropped silently
        do_reset();
        push(4'b1000);
        tick();
        check_val("scream_busy1", busy, 1'b1);
        tick();
        check_val("scream_busy2", busy, 1'b0);
        check_val("scream_sound", sound, 2'b00);
        check_val("scream_err", err_cnt, 4'd0);

        // WAVE + 5xJAW with op_valid held: back-pressure and ordered effects
        do_reset();
        push(4'b0000);
        wait_idle("bp_on_idle");
        n_acc    = 0;
        op_valid = 1'b1;
        opcode   = 4'b1100;
        for (int k = 1; k <= 40; k++) begin
            fire = op_valid && op_ready;
            tick();
            if (fire) begin
                n_acc++;
                opcode = 4'b1101;
                if (n_acc == 6) op_valid = 1'b0;
            end
            exp_mot = 2'b00;
            if (k >= 3 && k <= 6) exp_mot = 2'b01;
            for (int j = 0; j < 5; j++) begin
                if (k >= 9 + 6 * j && k <= 12 + 6 * j) exp_mot = 2'b10;
            end
            check_val($sformatf("bp_fx_k%0d", k), {sound, motion}, {2'b00, exp_mot});
            if (k == 5) check_val("bp_ready_full", op_ready, 1'b0);
            if (k == 8) check_val("bp_ready_pop", op_ready, 1'b1);
        end
        check_val("bp_accepted", n_acc, 6);
        check_val("bp_busy_end", busy, 1'b0);

        // undefined opcode counts and saturates
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            push(4'b0011);
            wait_idle("err_idle");
            check_val($sformatf("err_cnt_%0d", i), err_cnt, (i > 15) ? 15 : i);
        end
        check_val("err_not_enabled", enabled, 1'b0);

        // RESET flushes the queued FOG
        do_reset();
        push(4'b0000);
        push(4'b0110);
        push(4'b0001);
        push(4'b1110);
        bad        = 0;
        saw_orange = 0;
        saw_block  = 0;
        for (int k = 0; k < 30; k++) begin
            if (motion == 2'b11) bad++;
            if (led_color == 2'b11) saw_orange = 1;
            if (!op_ready) saw_block = 1;
            tick();
        end
        check_val("flush_saw_orange", saw_orange, 1);
        check_val("flush_saw_block", saw_block, 1);
        check_val("flush_no_fog", bad, 0);
        check_val("flush_led", led_color, 2'b00);
        check_val("flush_enabled", enabled, 1'b0);
        check_val("flush_busy", busy, 1'b0);
        check_val("flush_ready", op_ready, 1'b1);

        // rst mid-HOLD aborts immediately and drops the queue
        do_reset();
        push(4'b0000);
        wait_idle("abort_on_idle");
        push(4'b1010);
        n = 0;
        while (sound != 2'b11 && n < 10) begin
            tick();
            n++;
        end
        check_val("abort_sound_on", sound, 2'b11);
        push(4'b0101);
        check_val("abort_busy_pre", busy, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_val("abort_sound", sound, 2'b00);
        check_val("abort_motion", motion, 2'b00);
        check_val("abort_enabled", enabled, 1'b0);
        check_val("abort_led", led_color, 2'b00);
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_ready", op_ready, 1'b1);
        #2;
        rst = 1'b0;
        repeat (5) tick();
        check_val("abort_queue_lost", led_color, 2'b00);
        check_val("abort_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
